// File: rtl/rv_alu_pkg.sv
// Shared ALU definitions: operand/register widths, select encodings and the
// load-tracking state type used by the issue stage.
package rv_alu_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRA  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_MUL  = 4'd7,
    ALU_MULH = 4'd8,
    ALU_DIV  = 4'd9,
    ALU_REM  = 4'd10,
    ALU_SUB  = 4'd11
  } alu_sel_e;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_PEND = 1'b1
  } ld_state_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Operand source select for one register read: x0, in-stage ALU result,
// writeback data, or register-file data, in that priority.
module operand_fwd_mux
  import rv_alu_pkg::*;
(
  input  logic [RA_W-1:0] rs_i,
  input  logic [XLEN-1:0] rf_val_i,
  input  logic            ex_fwd_en_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            wb_valid_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] val_o
);

  always_comb begin
    val_o = rf_val_i;
    if (rs_i == '0)
      val_o = '0;
    else if (ex_fwd_en_i && (ex_rd_i == rs_i))
      val_o = ex_data_i;
    else if (wb_valid_i && (wb_rd_i == rs_i))
      val_o = wb_data_i;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register ahead of the ALU: operand forwarding, load-use interlock,
// valid/ready handshake toward decode and MEM, and flush.
//
//   state   | meaning
//   LD_IDLE | no load result outstanding
//   LD_PEND | a load to load_rd_q has left the stage, data not yet written back
module alu_issue_stage
  import rv_alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [RA_W-1:0] dec_rs1,
  input  logic [RA_W-1:0] dec_rs2,
  input  logic [XLEN-1:0] dec_rs1_val,
  input  logic [XLEN-1:0] dec_rs2_val,
  input  logic [XLEN-1:0] dec_imm,
  input  logic            dec_use_imm,
  input  logic [3:0]      dec_sel,
  input  logic            dec_un,
  input  logic [RA_W-1:0] dec_rd,
  input  logic            dec_we,
  input  logic            dec_load,
  input  logic [XLEN-1:0] alu_result,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [3:0]      alu_s,
  output logic            alu_un,
  output logic [RA_W-1:0] out_rd,
  output logic            out_we,
  output logic            out_load
);

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic [3:0]      alu_s_q, alu_s_d;
  logic            alu_un_q, alu_un_d;
  logic [RA_W-1:0] out_rd_q, out_rd_d;
  logic            out_we_q, out_we_d, out_load_q, out_load_d;
  ld_state_e       ld_state_q, ld_state_d;
  logic [RA_W-1:0] load_rd_q, load_rd_d;

  logic            ex_fwd_en, rs2_used, wb_hits_pend, ex_load_blk, pend_blk;
  logic            hazard, accept, xfer, ld_set;
  logic [XLEN-1:0] rs1_res, rs2_res;

  // A load's own ALU output is an address, never forwardable data.
  assign ex_fwd_en    = out_valid_q & out_we_q & ~out_load_q;
  assign rs2_used     = ~dec_use_imm;
  assign wb_hits_pend = wb_valid & (wb_rd == load_rd_q);

  assign ex_load_blk = out_valid_q & out_load_q & out_we_q & (out_rd_q != '0) &
                       ((dec_rs1 == out_rd_q) | (rs2_used & (dec_rs2 == out_rd_q)));
  assign pend_blk    = (ld_state_q == LD_PEND) & ~wb_hits_pend &
                       ((dec_rs1 == load_rd_q) | (rs2_used & (dec_rs2 == load_rd_q)));
  assign hazard      = dec_valid & (ex_load_blk | pend_blk);

  assign dec_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
  assign accept    = dec_valid & dec_ready;
  assign xfer      = out_valid_q & out_ready;
  assign ld_set    = xfer & out_load_q & out_we_q & (out_rd_q != '0);

  operand_fwd_mux u_fwd_rs1 (
    .rs_i        (dec_rs1),
    .rf_val_i    (dec_rs1_val),
    .ex_fwd_en_i (ex_fwd_en),
    .ex_rd_i     (out_rd_q),
    .ex_data_i   (alu_result),
    .wb_valid_i  (wb_valid),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_data),
    .val_o       (rs1_res)
  );

  operand_fwd_mux u_fwd_rs2 (
    .rs_i        (dec_rs2),
    .rf_val_i    (dec_rs2_val),
    .ex_fwd_en_i (ex_fwd_en),
    .ex_rd_i     (out_rd_q),
    .ex_data_i   (alu_result),
    .wb_valid_i  (wb_valid),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_data),
    .val_o       (rs2_res)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    alu_s_d     = alu_s_q;
    alu_un_d    = alu_un_q;
    out_rd_d    = out_rd_q;
    out_we_d    = out_we_q;
    out_load_d  = out_load_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_x_d     = rs1_res;
      alu_y_d     = dec_use_imm ? dec_imm : rs2_res;
      alu_s_d     = dec_sel;
      alu_un_d    = dec_un;
      out_rd_d    = dec_rd;
      out_we_d    = dec_we;
      out_load_d  = dec_load;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // A newly departing load replaces any older pending one.
  always_comb begin
    ld_state_d = ld_state_q;
    load_rd_d  = load_rd_q;
    if (flush) begin
      ld_state_d = LD_IDLE;
    end else if (ld_set) begin
      ld_state_d = LD_PEND;
      load_rd_d  = out_rd_q;
    end else if ((ld_state_q == LD_PEND) && wb_hits_pend) begin
      ld_state_d = LD_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_s_q     <= '0;
      alu_un_q    <= 1'b0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
      out_load_q  <= 1'b0;
      ld_state_q  <= LD_IDLE;
      load_rd_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      alu_s_q     <= alu_s_d;
      alu_un_q    <= alu_un_d;
      out_rd_q    <= out_rd_d;
      out_we_q    <= out_we_d;
      out_load_q  <= out_load_d;
      ld_state_q  <= ld_state_d;
      load_rd_q   <= load_rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_s     = alu_s_q;
  assign alu_un    = alu_un_q;
  assign out_rd    = out_rd_q;
  assign out_we    = out_we_q;
  assign out_load  = out_load_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the held op and pending load.
module tb_alu_issue_stage;
  import rv_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic [4:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0, wb_rd = '0, out_rd;
  logic [31:0] dec_rs1_val = '0, dec_rs2_val = '0, dec_imm = '0;
  logic        dec_use_imm = 1'b0, dec_un = 1'b0, dec_we = 1'b0, dec_load = 1'b0;
  logic [3:0]  dec_sel = '0, alu_s;
  logic [31:0] alu_result = '0, wb_data = '0, alu_x, alu_y;
  logic        wb_valid = 1'b0, out_valid, out_ready = 1'b1;
  logic        alu_un, out_we, out_load;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_sel(dec_sel), .dec_un(dec_un),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_load(dec_load),
    .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s), .alu_un(alu_un),
    .out_rd(out_rd), .out_we(out_we), .out_load(out_load)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the op currently held (m_*) and the outstanding load (p_*).
  logic        m_v, m_un, m_we, m_ld;
  logic [31:0] m_x, m_y;
  logic [3:0]  m_s;
  logic [4:0]  m_rd;
  logic        p_pend;
  logic [4:0]  p_rd;
  logic        last_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_v = 0; m_un = 0; m_we = 0; m_ld = 0; m_x = 0; m_y = 0; m_s = 0; m_rd = 0;
    p_pend = 0; p_rd = 0;
  endfunction

  function automatic logic reads(input logic [4:0] r);
    return (dec_rs1 == r) || (!dec_use_imm && dec_rs2 == r);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'h0;
    if (m_v && m_we && !m_ld && m_rd == rs) return alu_result;
    if (wb_valid && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  function automatic logic expected_ready();
    logic load_in_ex, load_outstanding;
    load_in_ex       = m_v && m_ld && m_we && m_rd != 0 && reads(m_rd);
    load_outstanding = p_pend && reads(p_rd) && !(wb_valid && wb_rd == p_rd);
    return (!m_v || out_ready) && !flush && !(dec_valid && (load_in_ex || load_outstanding));
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, m_v});
    if (m_v) begin
      check({tag, ".alu_x"}, alu_x, m_x);
      check({tag, ".alu_y"}, alu_y, m_y);
      check({tag, ".alu_s"}, {28'b0, alu_s}, {28'b0, m_s});
      check({tag, ".ctl"}, {24'b0, alu_un, out_we, out_load, out_rd},
            {24'b0, m_un, m_we, m_ld, m_rd});
    end
  endtask

  // Called just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic step(input string tag);
    logic        er, acc, xfer, n_v, n_pend;
    logic [31:0] nx, ny;
    logic [4:0]  n_prd;
    #1;
    er = expected_ready();
    check({tag, ".dec_ready"}, {31'b0, dec_ready}, {31'b0, er});
    last_ready = dec_ready;
    acc  = dec_valid && er;
    xfer = m_v && out_ready;
    nx   = operand(dec_rs1, dec_rs1_val);
    ny   = dec_use_imm ? dec_imm : operand(dec_rs2, dec_rs2_val);
    n_pend = p_pend; n_prd = p_rd;
    if (flush) n_pend = 0;
    else if (xfer && m_ld && m_we && m_rd != 0) begin n_pend = 1; n_prd = m_rd; end
    else if (p_pend && wb_valid && wb_rd == p_rd) n_pend = 0;
    n_v = m_v;
    if (flush) n_v = 0;
    else if (acc) n_v = 1;
    else if (xfer) n_v = 0;
    @(posedge clk);
    if (!flush && acc) begin
      m_x = nx; m_y = ny; m_s = dec_sel; m_un = dec_un;
      m_rd = dec_rd; m_we = dec_we; m_ld = dec_load;
    end
    m_v = n_v; p_pend = n_pend; p_rd = n_prd;
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [4:0] rs1, input logic [31:0] v1,
                        input logic [4:0] rs2, input logic [31:0] v2,
                        input logic [31:0] imm, input logic use_imm, input logic [3:0] sel,
                        input logic [4:0] rd, input logic we, input logic ld);
    dec_valid = 1; dec_rs1 = rs1; dec_rs1_val = v1; dec_rs2 = rs2; dec_rs2_val = v2;
    dec_imm = imm; dec_use_imm = use_imm; dec_sel = sel; dec_un = 0;
    dec_rd = rd; dec_we = we; dec_load = ld;
  endtask

  logic [31:0] sx, sy;
  logic [3:0]  ss;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", {31'b0, out_valid}, 32'h0);
    check("reset.alu_x", alu_x, 32'h0);
    check("reset.ctl", {24'b0, alu_un, out_we, out_load, out_rd, alu_s}, 32'h0);
    @(negedge clk);
    rst_n = 1;

    // Back-to-back dependent ALU ops: SUB takes ADD's result via alu_result.
    set_op(5'd1, 32'h3, 5'd2, 32'hD, 0, 0, ALU_ADD, 5'd5, 1, 0);
    step("t2a");
    check("t2a.alu_x", alu_x, 32'h3);
    check("t2a.alu_s", {28'b0, alu_s}, 32'd2);
    set_op(5'd5, 32'h99, 5'd3, 32'h4, 0, 0, ALU_SUB, 5'd6, 1, 0);
    alu_result = 32'h10;
    step("t2b");
    check("t2b.alu_x", alu_x, 32'h10);
    check("t2b.alu_s", {28'b0, alu_s}, 32'd11);

    // Asynchronous reset with an op held: outputs clear without a clock edge.
    dec_valid = 0;
    check("t1.pre_valid", {31'b0, out_valid}, 32'h1);
    rst_n = 0;
    #1;
    check("t1.out_valid", {31'b0, out_valid}, 32'h0);
    check("t1.alu_x", alu_x, 32'h0);
    check("t1.alu_y", alu_y, 32'h0);
    check("t1.ctl", {24'b0, alu_un, out_we, out_load, out_rd, alu_s}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // Load-use: one bubble, then writeback data forwarded in the wb cycle.
    set_op(5'd1, 32'h100, 5'd0, 0, 32'h4, 1, ALU_ADD, 5'd7, 1, 1);
    step("t3a");
    set_op(5'd7, 32'h55, 5'd1, 32'h20, 0, 0, ALU_ADD, 5'd8, 1, 0);
    step("t3b");
    check("t3.bubble", {31'b0, last_ready}, 32'h0);
    check("t3.model_pend", {27'b0, p_pend, p_rd}, 32'h27);
    wb_valid = 1; wb_rd = 5'd7; wb_data = 32'hAB;
    step("t3c");
    check("t3.accept", {31'b0, last_ready}, 32'h1);
    check("t3.alu_x", alu_x, 32'hAB);
    check("t3.alu_y", alu_y, 32'h20);
    wb_valid = 0;

    // Backpressure: held op stable, incoming op not dropped.
    sx = alu_x; sy = alu_y; ss = alu_s;
    out_ready = 0;
    set_op(5'd2, 32'h1111, 5'd3, 32'h2222, 0, 0, ALU_XOR, 5'd12, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step("t4hold");
      check("t4.ready", {31'b0, last_ready}, 32'h0);
      check("t4.stable", {alu_x ^ sx} | {alu_y ^ sy} | {28'b0, alu_s ^ ss}, 32'h0);
    end
    out_ready = 1;
    step("t4go");
    check("t4.accept", {31'b0, last_ready}, 32'h1);
    check("t4.alu_x", alu_x, 32'h1111);

    // x0 is never forwarded.
    set_op(5'd1, 32'h5, 5'd2, 32'h6, 0, 0, ALU_ADD, 5'd0, 1, 0);
    step("t5a");
    set_op(5'd0, 32'hFFFF, 5'd0, 32'hFFFF, 0, 0, ALU_OR, 5'd9, 1, 0);
    alu_result = 32'h1234; wb_valid = 1; wb_rd = 5'd0; wb_data = 32'h77;
    step("t5b");
    check("t5.alu_x", alu_x, 32'h0);
    check("t5.alu_y", alu_y, 32'h0);
    wb_valid = 0;

    // Flush clears held op and pending load; dependent op then issues.
    set_op(5'd1, 32'h10, 5'd0, 0, 32'h8, 1, ALU_ADD, 5'd9, 1, 1);
    step("t6a");
    set_op(5'd1, 32'h1, 5'd2, 32'h2, 0, 0, ALU_ADD, 5'd10, 1, 0);
    step("t6b");
    check("t6.model_pend", {27'b0, p_pend, p_rd}, 32'h29);
    set_op(5'd9, 32'h33, 5'd1, 32'h0, 0, 0, ALU_ADD, 5'd11, 1, 0);
    flush = 1;
    step("t6c");
    check("t6.flush_ready", {31'b0, last_ready}, 32'h0);
    check("t6.out_valid", {31'b0, out_valid}, 32'h0);
    flush = 0;
    step("t6d");
    check("t6.no_stall", {31'b0, last_ready}, 32'h1);
    check("t6.alu_x", alu_x, 32'h33);

    // Random traffic over a small register window to provoke hazards and forwarding.
    for (int n = 0; n < 3000; n++) begin
      dec_valid   = ($urandom_range(0, 3) != 0);
      dec_rs1     = 5'($urandom_range(0, 7));
      dec_rs2     = 5'($urandom_range(0, 7));
      dec_rs1_val = $urandom;
      dec_rs2_val = $urandom;
      dec_imm     = $urandom;
      dec_use_imm = 1'($urandom_range(0, 1));
      dec_sel     = 4'($urandom_range(0, 11));
      dec_un      = 1'($urandom_range(0, 1));
      dec_rd      = 5'($urandom_range(0, 7));
      dec_we      = ($urandom_range(0, 4) != 0);
      dec_load    = ($urandom_range(0, 3) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      wb_valid    = ($urandom_range(0, 2) == 0);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      alu_result  = $urandom;
      flush       = ($urandom_range(0, 19) == 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
